// File: rtl/rx_blk_pkg.sv
// rtl/rx_blk_pkg.sv - shared state type, sync header and width-select constants for the RX block sequencer
package rx_blk_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_SB = 2'd1,
    IN_BLK  = 2'd2
  } rx_blk_state_t;

  localparam logic [1:0] SH_DATA = 2'b10;
  localparam logic [1:0] SH_OS   = 2'b01;

  localparam logic [1:0] WS_8B  = 2'd0;
  localparam logic [1:0] WS_16B = 2'd1;
  localparam logic [1:0] WS_32B = 2'd2;

  // Index of the final PIPE word in a 128-bit block payload; reserved width acts as 32b.
  function automatic logic [3:0] last_word_idx(input logic [1:0] width_sel);
    case (width_sel)
      WS_8B:   return 4'd15;
      WS_16B:  return 4'd7;
      WS_32B:  return 4'd3;
      default: return 4'd3;
    endcase
  endfunction

endpackage

// File: rtl/rx_blk_word_cnt.sv
// rtl/rx_blk_word_cnt.sv - word-within-block counter with clear / load-to-1 / increment
module rx_blk_word_cnt #(
  parameter int CNT_WIDTH = 4
) (
  input  logic                 CLK,
  input  logic                 Hard_RST_L,
  input  logic                 rst,
  input  logic                 set,
  input  logic                 en,
  output logic [CNT_WIDTH-1:0] cnt
);

  always_ff @(posedge CLK or negedge Hard_RST_L) begin
    if (!Hard_RST_L)  cnt <= '0;
    else if (rst)     cnt <= '0;
    else if (set)     cnt <= CNT_WIDTH'(1);
    else if (en)      cnt <= cnt + CNT_WIDTH'(1);
  end

endmodule

// File: rtl/rx_block_sequencer.sv
// rtl/rx_block_sequencer.sv - 128b/130b RX block framing sequencer driving the PIPE word counter
// Optional saturating error counter enabled by defining RX_BLK_ERR_CNT_EN.
module rx_block_sequencer
  import rx_blk_pkg::*;
#(
  parameter int CNT_WIDTH     = 4,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     CLK,
  input  logic                     Hard_RST_L,
  input  logic                     i_link_en,
  input  logic                     i_rx_valid,
  input  logic                     i_rx_data_valid,
  input  logic                     i_rx_start_block,
  input  logic [1:0]               i_sync_hdr,
  input  logic [1:0]               i_width_sel,
  output logic                     o_cnt_rst,
  output logic                     o_cnt_set,
  output logic                     o_cnt_en,
  output logic [CNT_WIDTH-1:0]     o_word_idx,
  output logic                     o_blk_first,
  output logic                     o_blk_last,
  output logic                     o_blk_is_os,
  output logic                     o_sync_err,
  output logic                     o_align_err,
  output logic                     o_locked,
  output logic [ERR_CNT_WIDTH-1:0] o_err_cnt
);

  rx_blk_state_t        state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] last;
  logic                 wv, sb, hdr_ok, at_boundary;
  logic                 sync_err_c, align_err_c, latch_hdr, is_os_q;

  assign wv          = i_rx_valid & i_rx_data_valid;
  assign sb          = wv & i_rx_start_block;
  assign hdr_ok      = (i_sync_hdr == SH_DATA) || (i_sync_hdr == SH_OS);
  assign last        = CNT_WIDTH'(last_word_idx(i_width_sel));
  // The counter is cleared after the last word, so zero inside IN_BLK means a block must start next.
  assign at_boundary = (cnt == '0);

  rx_blk_word_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_word_cnt (
    .CLK        (CLK),
    .Hard_RST_L (Hard_RST_L),
    .rst        (o_cnt_rst),
    .set        (o_cnt_set),
    .en         (o_cnt_en),
    .cnt        (cnt)
  );

  always_ff @(posedge CLK or negedge Hard_RST_L) begin
    if (!Hard_RST_L) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!i_link_en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = WAIT_SB;
        WAIT_SB: if (sb && hdr_ok) state_nxt = IN_BLK;
        IN_BLK: begin
          if (!i_rx_valid)               state_nxt = WAIT_SB;
          else if (sb && !hdr_ok)        state_nxt = WAIT_SB;
          else if (wv && !sb && at_boundary) state_nxt = WAIT_SB;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    o_cnt_rst   = 1'b0;
    o_cnt_set   = 1'b0;
    o_cnt_en    = 1'b0;
    o_blk_first = 1'b0;
    o_blk_last  = 1'b0;
    o_word_idx  = '0;
    sync_err_c  = 1'b0;
    align_err_c = 1'b0;
    latch_hdr   = 1'b0;
    if (!i_link_en || state == IDLE) begin
      o_cnt_rst = Hard_RST_L;
    end else if (state == WAIT_SB) begin
      if (sb) begin
        if (hdr_ok) begin
          o_cnt_set   = 1'b1;
          o_blk_first = 1'b1;
          latch_hdr   = 1'b1;
        end else begin
          sync_err_c  = 1'b1;
        end
      end
    end else if (state == IN_BLK && i_rx_valid) begin
      o_word_idx = cnt;
      if (sb) begin
        o_word_idx  = '0;
        align_err_c = !at_boundary;
        if (hdr_ok) begin
          o_cnt_set   = 1'b1;
          o_blk_first = 1'b1;
          latch_hdr   = 1'b1;
        end else begin
          sync_err_c  = 1'b1;
        end
      end else if (wv) begin
        if (at_boundary) begin
          align_err_c = 1'b1;
        end else if (cnt == last) begin
          o_blk_last = 1'b1;
          o_cnt_rst  = 1'b1;
        end else begin
          o_cnt_en   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge Hard_RST_L) begin
    if (!Hard_RST_L) begin
      o_sync_err  <= 1'b0;
      o_align_err <= 1'b0;
      is_os_q     <= 1'b0;
    end else begin
      o_sync_err  <= sync_err_c;
      o_align_err <= align_err_c;
      if (state == IDLE)  is_os_q <= 1'b0;
      else if (latch_hdr) is_os_q <= (i_sync_hdr == SH_OS);
    end
  end

  // Block type is visible on the start-block word itself, then held for the rest of the block.
  assign o_blk_is_os = latch_hdr ? (i_sync_hdr == SH_OS) : is_os_q;
  assign o_locked    = (state == IN_BLK);

`ifdef RX_BLK_ERR_CNT_EN
  logic [ERR_CNT_WIDTH-1:0] err_cnt;

  always_ff @(posedge CLK or negedge Hard_RST_L) begin
    if (!Hard_RST_L)                                  err_cnt <= '0;
    else if (state == IDLE && state_nxt == WAIT_SB)   err_cnt <= '0;
    else if ((o_sync_err || o_align_err) && (err_cnt != '1))
      err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
  end

  assign o_err_cnt = err_cnt;
`else
  assign o_err_cnt = '0;
`endif

endmodule

// File: tb/tb_rx_block_sequencer.sv
// tb/tb_rx_block_sequencer.sv - randomized self-checking bench for rx_block_sequencer against a block-position model
module tb_rx_block_sequencer;

  localparam int CW = 4;
  localparam int EW = 8;

  logic          CLK = 1'b0;
  logic          Hard_RST_L = 1'b0;
  logic          i_link_en = 1'b0;
  logic          i_rx_valid = 1'b0;
  logic          i_rx_data_valid = 1'b0;
  logic          i_rx_start_block = 1'b0;
  logic [1:0]    i_sync_hdr = 2'b00;
  logic [1:0]    i_width_sel = 2'b00;
  logic          o_cnt_rst, o_cnt_set, o_cnt_en;
  logic [CW-1:0] o_word_idx;
  logic          o_blk_first, o_blk_last, o_blk_is_os;
  logic          o_sync_err, o_align_err, o_locked;
  logic [EW-1:0] o_err_cnt;

  always #5 CLK = ~CLK;

  rx_block_sequencer #(.CNT_WIDTH(CW), .ERR_CNT_WIDTH(EW)) dut (
    .CLK              (CLK),
    .Hard_RST_L       (Hard_RST_L),
    .i_link_en        (i_link_en),
    .i_rx_valid       (i_rx_valid),
    .i_rx_data_valid  (i_rx_data_valid),
    .i_rx_start_block (i_rx_start_block),
    .i_sync_hdr       (i_sync_hdr),
    .i_width_sel      (i_width_sel),
    .o_cnt_rst        (o_cnt_rst),
    .o_cnt_set        (o_cnt_set),
    .o_cnt_en         (o_cnt_en),
    .o_word_idx       (o_word_idx),
    .o_blk_first      (o_blk_first),
    .o_blk_last       (o_blk_last),
    .o_blk_is_os      (o_blk_is_os),
    .o_sync_err       (o_sync_err),
    .o_align_err      (o_align_err),
    .o_locked         (o_locked),
    .o_err_cnt        (o_err_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: phase 0=off, 1=hunting for a start block, 2=inside a block;
  // pos = index the next word would carry, equal to the block length once the block is complete.
  int phase = 0;
  int pos = 0;
  bit blk_os = 1'b0;
  bit prev_serr = 1'b0;
  bit prev_aerr = 1'b0;
  int errcnt = 0;

  function automatic int block_words();
    return 16 >> ((i_width_sel > 2'd2) ? 2 : int'(i_width_sel));
  endfunction

  task automatic cycle(input bit le, input bit rv, input bit dv, input bit sbk, input logic [1:0] hdr);
    int  bw, nphase, e_idx;
    bit  wv, legal, e_rst, e_set, e_en, e_first, e_last, e_serr, e_aerr, e_word;
    i_link_en = le; i_rx_valid = rv; i_rx_data_valid = dv;
    i_rx_start_block = sbk; i_sync_hdr = hdr;
    @(negedge CLK);
    bw = block_words();
    wv = rv && dv;
    legal = (hdr == 2'b01) || (hdr == 2'b10);
    {e_rst, e_set, e_en, e_first, e_last, e_serr, e_aerr, e_word} = '0;
    e_idx = 0;
    nphase = phase;
    if (!le) begin
      e_rst = 1'b1; nphase = 0;
    end else if (phase == 0) begin
      e_rst = 1'b1; nphase = 1;
    end else if (!(phase == 2 && !rv) && wv && sbk) begin
      if (phase == 2 && pos != bw) e_aerr = 1'b1;
      if (legal) begin
        e_set = 1'b1; e_first = 1'b1; e_word = 1'b1; e_idx = 0;
        blk_os = (hdr == 2'b01); pos = 1; nphase = 2;
      end else begin
        e_serr = 1'b1; nphase = 1;
      end
    end else if (phase == 2) begin
      if (!rv) nphase = 1;
      else if (wv && pos == bw) begin
        e_aerr = 1'b1; nphase = 1;
      end else if (wv) begin
        e_word = 1'b1; e_idx = pos;
        if (pos == bw - 1) begin e_last = 1'b1; e_rst = 1'b1; end
        else e_en = 1'b1;
        pos++;
      end
    end
    check("locked", o_locked, phase == 2);
    check("cnt_rst", o_cnt_rst, e_rst);
    check("cnt_set", o_cnt_set, e_set);
    check("cnt_en", o_cnt_en, e_en);
    check("blk_first", o_blk_first, e_first);
    check("blk_last", o_blk_last, e_last);
    if (e_word) check("word_idx", o_word_idx, e_idx);
    if (phase == 2 || nphase == 2) check("blk_is_os", o_blk_is_os, blk_os);
    check("sync_err", o_sync_err, prev_serr);
    check("align_err", o_align_err, prev_aerr);
`ifdef RX_BLK_ERR_CNT_EN
    check("err_cnt", o_err_cnt, errcnt);
    if (phase == 0 && le) errcnt = 0;
    else if ((prev_serr || prev_aerr) && errcnt < (1 << EW) - 1) errcnt++;
`else
    check("err_cnt", o_err_cnt, 0);
`endif
    prev_serr = e_serr;
    prev_aerr = e_aerr;
    phase = nphase;
    @(posedge CLK); #1;
  endtask

  task automatic reset_now();
    Hard_RST_L = 1'b0;
    #1;
    check("rst_flags", {o_cnt_rst, o_cnt_set, o_cnt_en, o_blk_first, o_blk_last,
                        o_blk_is_os, o_sync_err, o_align_err, o_locked}, 0);
    check("rst_idx", o_word_idx, 0);
    check("rst_err_cnt", o_err_cnt, 0);
    {i_link_en, i_rx_valid, i_rx_data_valid, i_rx_start_block} = '0;
    i_sync_hdr = 2'b00;
    @(posedge CLK);
    @(negedge CLK);
    Hard_RST_L = 1'b1;
    phase = 0; pos = 0; blk_os = 1'b0; prev_serr = 1'b0; prev_aerr = 1'b0; errcnt = 0;
    @(posedge CLK); #1;
  endtask

  task automatic set_width(input logic [1:0] w);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    i_width_sel = w;
  endtask

  task automatic word();
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
  endtask

  task automatic start(input logic [1:0] hdr);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, hdr);
  endtask

  initial begin
    reset_now();

    set_width(2'd0); cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    start(2'b10); repeat (15) word();
    start(2'b10); repeat (15) word();

    set_width(2'd2); cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    start(2'b01); repeat (3) word();
    start(2'b10); repeat (3) word();

    set_width(2'd1); cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    start(2'b10); repeat (3) word();
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
    repeat (4) word();
    word();

    set_width(2'd0); cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    start(2'b10); repeat (4) word();
    start(2'b01); repeat (15) word();

    set_width(2'd0); cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    start(2'b11); word(); word();
    repeat (260) start(2'b00);
    word(); word();

    start(2'b10); repeat (9) word();
    reset_now();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    start(2'b01); repeat (15) word();
    start(2'b00); start(2'b10); word();

    for (int n = 0; n < 3000; n++) begin
      bit le, rv, dv, sbk;
      logic [1:0] hdr;
      if (n % 250 == 249) begin
        set_width(2'($urandom_range(0, 3)));
      end else begin
        le  = ($urandom_range(0, 99) != 0);
        rv  = ($urandom_range(0, 99) < 95);
        dv  = ($urandom_range(0, 99) < 85);
        if (phase == 2 && pos == block_words()) sbk = ($urandom_range(0, 99) < 85);
        else                                     sbk = ($urandom_range(0, 99) < 8);
        if ($urandom_range(0, 99) < 85) hdr = $urandom_range(0, 1) ? 2'b01 : 2'b10;
        else                            hdr = $urandom_range(0, 1) ? 2'b00 : 2'b11;
        cycle(le, rv, dv, sbk, hdr);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_block_sequencer.md
Name: rx_block_sequencer

Overview:
- Controls the RX second-half PIPE word counter for 128b/130b blocks (Gen3+).
- Watches PIPE RxValid / RxDataValid / RxStartBlock / RxSyncHeader and generates counter reset / set / enable.
- Produces block-boundary flags (first/last word, block type) and flags framing errors.
- Sits between the PIPE RX interface and the descrambler / ordered-set decoder.

Parameters:
- CNT_WIDTH, 4, width of word index; must hold words-per-block minus 1 (max 15).
- ERR_CNT_WIDTH, 8, width of the optional saturating error counter.

Ports:
- CLK  input  1  clock
- Hard_RST_L  input  1  reset; asynchronous, active-low
- i_link_en  input  1  sequencer enable; low forces IDLE
- i_rx_valid  input  1  PIPE RxValid
- i_rx_data_valid  input  1  PIPE RxDataValid; low means the cycle holds no word
- i_rx_start_block  input  1  PIPE RxStartBlock
- i_sync_hdr  input  2  PIPE RxSyncHeader; sampled only on start-block cycles
- i_width_sel  input  2  PIPE data width: 0=8b, 1=16b, 2=32b, 3=reserved (treated as 32b)
- o_cnt_rst  output  1  counter synchronous clear
- o_cnt_set  output  1  counter load-to-1
- o_cnt_en  output  1  counter increment
- o_word_idx  output  CNT_WIDTH  index of the current word within its block
- o_blk_first  output  1  current word is word 0 of a block
- o_blk_last  output  1  current word is the final word of a block
- o_blk_is_os  output  1  block type latched at start block (hdr 2'b01 = ordered set, 2'b10 = data)
- o_sync_err  output  1  one-cycle pulse: illegal sync header
- o_align_err  output  1  one-cycle pulse: start block mid-block, or missing at a boundary
- o_locked  output  1  high while in IN_BLK
- o_err_cnt  output  ERR_CNT_WIDTH  error count (optional feature)

Behaviour:
- Reset: state=IDLE, word counter=0; all outputs 0.
- Word accepted (wv) = i_rx_valid & i_rx_data_valid. Cycles with wv=0 change nothing: no count, no flags.
- LAST = (16 >> min(i_width_sel,2)) - 1, giving 15 / 7 / 3. i_width_sel is static while o_locked; changing it while locked is undefined.
- IDLE:
  - o_cnt_rst=1 every cycle.
  - i_link_en=1 -> WAIT_SB.
- WAIT_SB:
  - Discard words until wv & i_rx_start_block.
  - Header 01 or 10: o_cnt_set=1, o_blk_first=1, word_idx=0, latch o_blk_is_os, -> IN_BLK.
  - Header 00 or 11: o_sync_err pulse, stay in WAIT_SB.
- IN_BLK, wv with no start block:
  - idx<LAST: o_cnt_en=1, o_word_idx = counter value.
  - idx==LAST: o_blk_last=1, o_cnt_rst=1 (next word must start a block).
  - Word arriving after LAST with no start block: o_align_err, -> WAIT_SB.
- IN_BLK, wv & start block:
  - Previous word was LAST: new block, handled as in WAIT_SB, stay IN_BLK.
  - Mid-block: o_align_err and restart the count at this block (set, first=1). An illegal header in this case additionally gives o_sync_err and -> WAIT_SB.
- Flag timing: o_word_idx, o_blk_first and o_blk_last are combinational with the accepted word (zero latency). Error pulses are registered (1-cycle latency).
- i_rx_valid=0 while locked: -> WAIT_SB, no error.
- i_link_en=0: -> IDLE from any state, next cycle.
- Priority: reset > ~i_link_en > ~i_rx_valid > start block > enable.
- Counter control outputs are mutually exclusive per cycle; rst has highest priority.

Optional Feature:
- RX_BLK_ERR_CNT_EN defined:
  - o_err_cnt increments on each o_sync_err or o_align_err; +1 even when both pulse in the same cycle.
  - Saturates at all-ones.
  - Cleared by reset or by leaving IDLE.
- Not defined: o_err_cnt tied to 0; no counter flops.

Decomposition:
- Shared package rx_blk_pkg:
  - typedef enum {IDLE, WAIT_SB, IN_BLK} rx_blk_state_t.
  - Sync header constants SH_DATA=2'b10, SH_OS=2'b01.
  - Width-select encodings.
- Natural sub-module: rx_blk_word_cnt, a CNT_WIDTH counter with rst/set/en, instantiated once.

Test Plan:
- width_sel=0, SB hdr 10, then 15 valid words -> word_idx 0..15, blk_last on the 16th word, blk_is_os=0, no errors.
- width_sel=2, two back-to-back blocks (hdr 01 then 10) -> idx 0..3 twice, blk_first at each SB, blk_is_os 1 then 0.
- width_sel=1, data_valid low for 3 cycles mid-block -> idx holds, no flags during the gap; block still ends at idx 7.
- SB at idx 5 of a 16-word block -> o_align_err pulse, new block idx restarts at 0, stays locked.
- SB hdr 11 in WAIT_SB -> o_sync_err pulse, stays WAIT_SB; with RX_BLK_ERR_CNT_EN, o_err_cnt=1.
- Hard_RST_L low mid-block (idx 9) -> all outputs 0 immediately, state IDLE; after release, i_link_en=1 -> WAIT_SB.
